// File: rtl/tipi_fifo_bus.sv
// TI-bus window onto a TX FIFO (TI->Pi) and an RX FIFO (Pi->TI) with status/control,
// level registers, sticky error flags and a registered RX-threshold interrupt.
module tipi_fifo_bus #(
    parameter logic [15:0] BASE_ADDR = 16'h5ff9,
    parameter int          DEPTH     = 16,
    parameter int          PTR_W     = 4,
    parameter int          RX_THRESH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dev_en,
    input  logic [0:15] ti_a,
    input  logic        ti_memen,
    input  logic        ti_we,
    input  logic        ti_dbin,
    input  logic [0:7]  ti_wdata,
    output logic [0:7]  ti_rdata,
    output logic        ti_rdata_oe,
    output logic        irq_n,
    output logic [0:7]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [0:7]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int CW = PTR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] THR_CNT  = CW'(RX_THRESH);

    localparam logic [15:0] A_STATUS = BASE_ADDR;
    localparam logic [15:0] A_DATA   = BASE_ADDR + 16'd2;
    localparam logic [15:0] A_TXLVL  = BASE_ADDR + 16'd4;
    localparam logic [15:0] A_RXLVL  = BASE_ADDR + 16'd6;

    logic we_s1, we_s2, we_d;
    logic mem_s1, mem_s2, dbin_s1, dbin_s2;
    logic rd_prev, rd_sel, rdy_q;

    logic [0:7]       tx_mem [DEPTH];
    logic [0:7]       rx_mem [DEPTH];
    logic [PTR_W-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0]    tx_count, rx_count;
    logic             tx_ovf, rx_udf, irq_en;

    logic hit, wr_evt, wr_data, wr_ctrl, rd_live, rd_fall;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic flush_tx, flush_rx, clr_sticky, tx_ovf_set, rx_udf_set;
    logic irq_pending;
    logic [0:7] status;

    assign hit = dev_en && (ti_a == A_STATUS || ti_a == A_DATA ||
                            ti_a == A_TXLVL  || ti_a == A_RXLVL);

    // The write chain resets to the asserted level so a strobe already active at
    // reset release never looks like a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_s1   <= 1'b1;
            we_s2   <= 1'b1;
            we_d    <= 1'b1;
            mem_s1  <= 1'b0;
            mem_s2  <= 1'b0;
            dbin_s1 <= 1'b0;
            dbin_s2 <= 1'b0;
            rd_prev <= 1'b0;
            rd_sel  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            we_s1   <= ~ti_we;
            we_s2   <= we_s1;
            we_d    <= we_s2;
            mem_s1  <= ~ti_memen;
            mem_s2  <= mem_s1;
            dbin_s1 <= ti_dbin;
            dbin_s2 <= dbin_s1;
            rd_prev <= rd_live;
            rdy_q   <= 1'b1;
            if (rd_live && !rd_prev)
                rd_sel <= dev_en && (ti_a == A_DATA);
        end
    end

    assign wr_evt  = we_s2 && !we_d && mem_s2 && hit;
    assign wr_data = wr_evt && (ti_a == A_DATA);
    assign wr_ctrl = wr_evt && (ti_a == A_STATUS);
    assign rd_live = mem_s2 && dbin_s2;
    assign rd_fall = rd_prev && !rd_live && rd_sel;

    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd];
    assign rx_ready = rdy_q && !rx_full;

    assign flush_tx   = wr_ctrl && ti_wdata[0];
    assign flush_rx   = wr_ctrl && ti_wdata[1];
    assign clr_sticky = wr_ctrl && ti_wdata[2];
    assign tx_push    = wr_data && !tx_full;
    assign tx_ovf_set = wr_data && tx_full;
    assign tx_pop     = tx_valid && tx_ready;
    assign rx_push    = rx_valid && rx_ready;
    assign rx_pop     = rd_fall && !rx_empty;
    assign rx_udf_set = rd_fall && rx_empty;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= ti_wdata;
        if (rx_push) rx_mem[rx_wr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
            tx_ovf   <= 1'b0;
            rx_udf   <= 1'b0;
            irq_en   <= 1'b0;
            irq_n    <= 1'b1;
        end else begin
            if (flush_tx) begin
                tx_wr    <= '0;
                tx_rd    <= '0;
                tx_count <= '0;
            end else begin
                tx_wr    <= tx_wr + PTR_W'(tx_push);
                tx_rd    <= tx_rd + PTR_W'(tx_pop);
                tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            end
            if (flush_rx) begin
                rx_wr    <= '0;
                rx_rd    <= '0;
                rx_count <= '0;
            end else begin
                rx_wr    <= rx_wr + PTR_W'(rx_push);
                rx_rd    <= rx_rd + PTR_W'(rx_pop);
                rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
            end
            if (clr_sticky) begin
                tx_ovf <= 1'b0;
                rx_udf <= 1'b0;
            end else begin
                if (tx_ovf_set) tx_ovf <= 1'b1;
                if (rx_udf_set) rx_udf <= 1'b1;
            end
            if (wr_ctrl) irq_en <= ti_wdata[7];
            irq_n <= !irq_pending;
        end
    end

    assign irq_pending = irq_en && (rx_count >= THR_CNT);
    assign status = {!rx_empty, tx_full, tx_empty, rx_full, tx_ovf, rx_udf, irq_pending, irq_en};
    assign ti_rdata_oe = dev_en && !ti_memen && ti_dbin && hit;

    always_comb begin
        ti_rdata = 8'h00;
        if (ti_rdata_oe) begin
            if (ti_a == A_STATUS)     ti_rdata = status;
            else if (ti_a == A_DATA)  ti_rdata = rx_empty ? 8'h00 : rx_mem[rx_rd];
            else if (ti_a == A_TXLVL) ti_rdata = 8'(tx_count);
            else                      ti_rdata = 8'(rx_count);
        end
    end
endmodule

// File: tb/tb_tipi_fifo_bus.sv
// Directed bench for tipi_fifo_bus: CPU bus cycles, Pi-side handshakes, flags,
// interrupt, flush and mid-operation reset against hand-computed values.
module tb_tipi_fifo_bus;
    localparam logic [15:0] A_ST  = 16'h5ff9;
    localparam logic [15:0] A_DAT = 16'h5ffb;
    localparam logic [15:0] A_TXL = 16'h5ffd;
    localparam logic [15:0] A_RXL = 16'h5fff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dev_en = 1'b1;
    logic [0:15] ti_a = '0;
    logic        ti_memen = 1'b1;
    logic        ti_we = 1'b1;
    logic        ti_dbin = 1'b0;
    logic [0:7]  ti_wdata = '0;
    logic [0:7]  ti_rdata;
    logic        ti_rdata_oe;
    logic        irq_n;
    logic [0:7]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [0:7]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] popped;
    logic [7:0] rd;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    tipi_fifo_bus dut (
        .clk(clk), .rst_n(rst_n), .dev_en(dev_en), .ti_a(ti_a),
        .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin),
        .ti_wdata(ti_wdata), .ti_rdata(ti_rdata), .ti_rdata_oe(ti_rdata_oe),
        .irq_n(irq_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // side: 0 none, 1 Pi pops TX on the write's action edge, 2 Pi pushes RX on it
    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] d, input int side);
        @(negedge clk);
        ti_a = addr; ti_wdata = d; ti_memen = 1'b0; ti_we = 1'b0; ti_dbin = 1'b0;
        repeat (2) @(negedge clk);
        if (side == 1) begin popped = tx_data; tx_ready = 1'b1; end
        if (side == 2) begin rx_data = 8'h77; rx_valid = 1'b1; end
        @(negedge clk);
        tx_ready = 1'b0; rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        ti_we = 1'b1; ti_memen = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic cpu_read(input logic [15:0] addr, output logic [7:0] d);
        @(negedge clk);
        ti_a = addr; ti_memen = 1'b0; ti_dbin = 1'b1; ti_we = 1'b1;
        repeat (4) @(negedge clk);
        check_val("rd_oe", 16'(ti_rdata_oe), 16'd1);
        d = ti_rdata;
        ti_memen = 1'b1; ti_dbin = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        logic [7:0] v;
        cpu_read(addr, v);
        check_val(tag, 16'(v), 16'(exp));
    endtask

    task automatic pi_push(input logic [7:0] d);
        @(negedge clk);
        rx_data = d; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        // reset state
        #12;
        check_val("rst_tx_valid", 16'(tx_valid), 16'd0);
        check_val("rst_rx_ready", 16'(rx_ready), 16'd0);
        check_val("rst_irq_n", 16'(irq_n), 16'd1);
        check_val("rst_tx_data", 16'(tx_data), 16'h00);
        ti_a = A_ST; ti_memen = 1'b0; ti_dbin = 1'b1;
        #1;
        check_val("rst_status", 16'(ti_rdata), 16'h20);
        dev_en = 1'b0;
        #1;
        check_val("dev_en_off_oe", 16'(ti_rdata_oe), 16'd0);
        dev_en = 1'b1; ti_memen = 1'b1; ti_dbin = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_val("rx_ready_after_rst", 16'(rx_ready), 16'd1);

        // three writes, tx_valid latency, in-order pops
        @(negedge clk);
        ti_a = A_DAT; ti_wdata = 8'h11; ti_memen = 1'b0; ti_we = 1'b0;
        repeat (2) @(negedge clk);
        check_val("tx_valid_before_act", 16'(tx_valid), 16'd0);
        @(negedge clk);
        check_val("tx_valid_after_act", 16'(tx_valid), 16'd1);
        repeat (2) @(negedge clk);
        ti_we = 1'b1; ti_memen = 1'b1;
        repeat (3) @(negedge clk);
        cpu_write(A_DAT, 8'h22, 0);
        cpu_write(A_DAT, 8'h33, 0);
        read_chk("txlvl_3", A_TXL, 8'h03);
        @(negedge clk);
        check_val("pop0", 16'(tx_data), 16'h11);
        tx_ready = 1'b1;
        @(negedge clk);
        check_val("pop1", 16'(tx_data), 16'h22);
        @(negedge clk);
        check_val("pop2", 16'(tx_data), 16'h33);
        @(negedge clk);
        tx_ready = 1'b0;
        check_val("tx_valid_drained", 16'(tx_valid), 16'd0);

        // overflow
        for (int i = 0; i <= 16; i++) cpu_write(A_DAT, 8'(i), 0);
        read_chk("txlvl_full", A_TXL, 8'h10);
        read_chk("status_ovf", A_ST, 8'h48);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_val("ovf_order", 16'(tx_data), 16'(i));
            tx_ready = 1'b1;
        end
        @(negedge clk);
        tx_ready = 1'b0;
        check_val("ovf_byte_dropped", 16'(tx_valid), 16'd0);
        cpu_write(A_ST, 8'h20, 0);
        read_chk("status_ovf_clr", A_ST, 8'h20);

        // RX path and underflow
        pi_push(8'hA5);
        pi_push(8'h5A);
        read_chk("status_rx", A_ST, 8'hA0);
        read_chk("rxlvl_2", A_RXL, 8'h02);
        read_chk("rx_head0", A_DAT, 8'hA5);
        read_chk("rx_head1", A_DAT, 8'h5A);
        read_chk("rx_empty_read", A_DAT, 8'h00);
        read_chk("status_udf", A_ST, 8'h24);
        cpu_write(A_ST, 8'h20, 0);
        read_chk("status_udf_clr", A_ST, 8'h20);

        // interrupt
        cpu_write(A_ST, 8'h01, 0);
        read_chk("status_irq_en", A_ST, 8'h21);
        check_val("irq_idle", 16'(irq_n), 16'd1);
        pi_push(8'h3C);
        check_val("irq_latency", 16'(irq_n), 16'd1);
        @(negedge clk);
        check_val("irq_asserted", 16'(irq_n), 16'd0);
        read_chk("irq_rx_byte", A_DAT, 8'h3C);
        check_val("irq_released", 16'(irq_n), 16'd1);
        cpu_write(A_ST, 8'h00, 0);

        // streaming through pointer wrap with count held constant
        q.delete();
        for (int i = 0; i < 8; i++) begin
            cpu_write(A_DAT, 8'(8'h80 + i), 0);
            q.push_back(8'(8'h80 + i));
        end
        for (int i = 0; i < 32; i++) begin
            cpu_write(A_DAT, 8'(8'h90 + i), 1);
            check_val("stream_order", 16'(popped), 16'(q.pop_front()));
            q.push_back(8'(8'h90 + i));
        end
        read_chk("stream_level", A_TXL, 8'h08);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("stream_tail", 16'(tx_data), 16'(q.pop_front()));
            tx_ready = 1'b1;
        end
        @(negedge clk);
        tx_ready = 1'b0;
        check_val("stream_drained", 16'(tx_valid), 16'd0);

        // flush both with a same-cycle Pi push
        cpu_write(A_DAT, 8'h01, 0);
        cpu_write(A_DAT, 8'h02, 0);
        pi_push(8'h55);
        read_chk("pre_flush_rxlvl", A_RXL, 8'h01);
        cpu_write(A_ST, 8'hC0, 2);
        read_chk("flush_txlvl", A_TXL, 8'h00);
        read_chk("flush_rxlvl", A_RXL, 8'h00);
        check_val("flush_tx_valid", 16'(tx_valid), 16'd0);

        // reset in the middle of a write
        cpu_write(A_DAT, 8'h0A, 0);
        cpu_write(A_ST, 8'h01, 0);
        pi_push(8'h66);
        @(negedge clk);
        check_val("pre_rst_irq", 16'(irq_n), 16'd0);
        check_val("pre_rst_tx_valid", 16'(tx_valid), 16'd1);
        @(negedge clk);
        ti_a = A_DAT; ti_wdata = 8'hEE; ti_memen = 1'b0; ti_we = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_tx_valid", 16'(tx_valid), 16'd0);
        check_val("midrst_irq_n", 16'(irq_n), 16'd1);
        check_val("midrst_rx_ready", 16'(rx_ready), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("no_push_held", 16'(tx_valid), 16'd0);
        ti_we = 1'b1; ti_memen = 1'b1;
        repeat (4) @(negedge clk);
        check_val("no_push_after", 16'(tx_valid), 16'd0);
        read_chk("midrst_txlvl", A_TXL, 8'h00);
        read_chk("midrst_status", A_ST, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
